// File: rtl/cp_strip_sched.sv
// cp_strip_sched: receive-side cyclic-prefix removal scheduler.
// Tracks OFDM symbol timing on the sample stream, discards the LCP prefix
// samples and steers the NFFT body samples into a two-bank ping-pong buffer.
// Full banks are read out to the FFT as contiguous NFFT-cycle bursts.
// Only addresses and enables are generated here; sample data bypasses this block.
//
// Handshake semantics: STB_I is a valid-only strobe with no backpressure, so every
// sample with STB_I=1 is consumed in its cycle. FFT_RDY_I is a level that promises
// room for one whole burst; it is looked at only while the reader is idle, and
// once a burst starts it runs NFFT cycles without further qualification.
module cp_strip_sched #(
  parameter int LCP  = 16,
  parameter int NFFT = 64,
  parameter int AW   = 6
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          SYNC_I,
  input  logic          STB_I,
  input  logic          FFT_RDY_I,
  output logic          WR_EN_O,
  output logic          WR_BANK_O,
  output logic [AW-1:0] WR_ADDR_O,
  output logic          RD_EN_O,
  output logic          RD_BANK_O,
  output logic [AW-1:0] RD_ADDR_O,
  output logic          SOP_O,
  output logic          EOP_O,
  output logic          OVF_O,
  output logic [15:0]   SYM_CNT_O
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CP   = 2'd1,
    W_DATA = 2'd2,
    W_DROP = 2'd3
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_BURST = 2'd1,
    R_DONE  = 2'd2
  } r_state_t;

  localparam logic [7:0]    LCP_C    = 8'(LCP);
  localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  w_state_t      w_state_q, w_state_d;
  r_state_t      r_state_q, r_state_d;

  logic [7:0]    cp_cnt_q, cp_cnt_d;
  logic [AW-1:0] body_idx_q, body_idx_d;
  logic          wr_bank_q;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q;
  logic [1:0]    full_q;
  logic [15:0]   sym_cnt_q;
  logic          ovf_q;

  // ---------------------------------------------------------------------------
  // Sample classification shared by the write next-state and output logic
  // ---------------------------------------------------------------------------
  logic          accept;      // ordinary sample (valid, not a sync marker)
  logic          restart;     // sync marker: CP sample 0 of a new symbol
  logic          body_smp;    // this sample belongs to a symbol body
  logic [AW-1:0] cur_idx;     // body index of this sample
  logic          body_last;   // this sample is body index NFFT-1
  logic          sym_write;   // the current symbol is being stored, not dropped

  // Decode what the incoming sample means in the current write state.
  always_comb begin
    accept    = STB_I & ~SYNC_I;
    restart   = STB_I & SYNC_I;
    body_smp  = accept & (((w_state_q == W_CP) && (cp_cnt_q == LCP_C)) ||
                          (w_state_q == W_DATA) || (w_state_q == W_DROP));
    cur_idx   = (w_state_q == W_CP) ? '0 : body_idx_q;
    body_last = (cur_idx == LAST_IDX);
    // On body entry the target bank decides store vs drop; later the state does.
    sym_write = (w_state_q == W_DATA) ||
                ((w_state_q == W_CP) && !full_q[wr_bank_q]);
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------

  // Write FSM state register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Write next-state: sync restarts the symbol, body end wraps straight to the next CP.
  always_comb begin
    w_state_d  = w_state_q;
    cp_cnt_d   = cp_cnt_q;
    body_idx_d = body_idx_q;
    if (restart) begin
      w_state_d  = W_CP;
      cp_cnt_d   = 8'd1;
      body_idx_d = '0;
    end else if (body_smp) begin
      if (body_last) begin
        w_state_d  = W_CP;
        cp_cnt_d   = 8'd0;
        body_idx_d = '0;
      end else begin
        w_state_d  = sym_write ? W_DATA : W_DROP;
        body_idx_d = cur_idx + 1'b1;
      end
    end else if (accept && (w_state_q == W_CP)) begin
      cp_cnt_d = cp_cnt_q + 8'd1;
    end
  end

  logic          wr_en_d;
  logic          wr_bank_d;
  logic [AW-1:0] wr_addr_d;
  logic          sym_done;
  logic          drop_start;
  logic [1:0]    full_set;

  // Write outputs: buffer strobe for stored body samples, bank bookkeeping at symbol end.
  always_comb begin
    wr_en_d    = body_smp & sym_write;
    wr_bank_d  = wr_en_d & wr_bank_q;
    wr_addr_d  = wr_en_d ? cur_idx : '0;
    sym_done   = wr_en_d & body_last;
    drop_start = body_smp & (w_state_q == W_CP) & full_q[wr_bank_q];
    full_set   = {sym_done & wr_bank_q, sym_done & ~wr_bank_q};
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------

  // Read next-state: idle until the read bank is full and the FFT has room.
  always_comb begin
    r_state_d = r_state_q;
    rd_cnt_d  = rd_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q] && FFT_RDY_I) begin
          r_state_d = R_BURST;
          rd_cnt_d  = '0;
        end
      end
      R_BURST: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          r_state_d = R_DONE;
        end
      end
      R_DONE:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  logic          rd_en_d;
  logic          rd_bank_d;
  logic [AW-1:0] rd_addr_d;
  logic          sop_d;
  logic          eop_d;
  logic          rd_release;
  logic [1:0]    full_clr;

  // Read outputs: burst strobes, and bank release once the last read has gone out.
  always_comb begin
    rd_en_d    = (r_state_q == R_BURST);
    rd_bank_d  = rd_en_d & rd_bank_q;
    rd_addr_d  = rd_en_d ? rd_cnt_q : '0;
    sop_d      = rd_en_d && (rd_cnt_q == '0);
    eop_d      = rd_en_d && (rd_cnt_q == LAST_IDX);
    rd_release = (r_state_q == R_DONE);
    full_clr   = {rd_release & rd_bank_q, rd_release & ~rd_bank_q};
  end

  // ---------------------------------------------------------------------------
  // Shared bookkeeping
  // ---------------------------------------------------------------------------

  // Counters, bank pointers, full flags and the sticky overflow.
  // Writer and reader always own different banks, so set and clear never collide.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cp_cnt_q   <= 8'd0;
      body_idx_q <= '0;
      wr_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      sym_cnt_q  <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      cp_cnt_q   <= cp_cnt_d;
      body_idx_q <= body_idx_d;
      rd_cnt_q   <= rd_cnt_d;
      full_q     <= (full_q & ~full_clr) | full_set;
      if (sym_done) begin
        wr_bank_q <= ~wr_bank_q;
        sym_cnt_q <= sym_cnt_q + 16'd1;
      end
      if (rd_release) begin
        rd_bank_q <= ~rd_bank_q;
      end
      if (drop_start) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Registered buffer-side outputs, one cycle after the deciding sample/state.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      WR_EN_O   <= 1'b0;
      WR_BANK_O <= 1'b0;
      WR_ADDR_O <= '0;
      RD_EN_O   <= 1'b0;
      RD_BANK_O <= 1'b0;
      RD_ADDR_O <= '0;
      SOP_O     <= 1'b0;
      EOP_O     <= 1'b0;
    end else begin
      WR_EN_O   <= wr_en_d;
      WR_BANK_O <= wr_bank_d;
      WR_ADDR_O <= wr_addr_d;
      RD_EN_O   <= rd_en_d;
      RD_BANK_O <= rd_bank_d;
      RD_ADDR_O <= rd_addr_d;
      SOP_O     <= sop_d;
      EOP_O     <= eop_d;
    end
  end

  assign OVF_O     = ovf_q;
  assign SYM_CNT_O = sym_cnt_q;

endmodule

// File: tb/tb_cp_strip_sched.sv
// tb_cp_strip_sched: directed and randomized stimulus for cp_strip_sched,
// checked cycle by cycle against a sample-position reference model.
module tb_cp_strip_sched;

  localparam int LCP  = 16;
  localparam int NFFT = 64;
  localparam int AW   = 6;
  localparam int SYML = LCP + NFFT;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          SYNC_I = 1'b0;
  logic          STB_I = 1'b0;
  logic          FFT_RDY_I = 1'b0;
  logic          WR_EN_O;
  logic          WR_BANK_O;
  logic [AW-1:0] WR_ADDR_O;
  logic          RD_EN_O;
  logic          RD_BANK_O;
  logic [AW-1:0] RD_ADDR_O;
  logic          SOP_O;
  logic          EOP_O;
  logic          OVF_O;
  logic [15:0]   SYM_CNT_O;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  chk_en   = 1'b0;
  bit  rdy_lvl  = 1'b0;
  bit  rdy_rand = 1'b0;

  // expected bank of each upcoming burst start, pushed by directed tests
  logic [0:0] exp_q[$];

  cp_strip_sched #(.LCP(LCP), .NFFT(NFFT), .AW(AW)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .SYNC_I(SYNC_I), .STB_I(STB_I),
    .FFT_RDY_I(FFT_RDY_I), .WR_EN_O(WR_EN_O), .WR_BANK_O(WR_BANK_O),
    .WR_ADDR_O(WR_ADDR_O), .RD_EN_O(RD_EN_O), .RD_BANK_O(RD_BANK_O),
    .RD_ADDR_O(RD_ADDR_O), .SOP_O(SOP_O), .EOP_O(EOP_O), .OVF_O(OVF_O),
    .SYM_CNT_O(SYM_CNT_O)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK_I = ~CLK_I;

  task automatic do_reset();
    @(posedge CLK_I);
    #1;
    RST_I  = 1'b1;
    SYNC_I = 1'b0;
    STB_I  = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The stream is tracked as a position within the LCP+NFFT symbol since the
  // last sync; the reader as a phase count since its start decision.
  int          pos = -1;
  bit          m_full [2];
  bit          m_wb, m_rb, m_sym_ok, m_ovf;
  logic [15:0] m_sym;
  int          rd_k = -1;
  logic          e_wr_en, e_wr_bank, e_rd_en, e_rd_bank, e_sop, e_eop;
  logic [AW-1:0] e_wr_addr, e_rd_addr;

  always @(posedge CLK_I or posedge RST_I) begin : model
    bit full_pre [2];
    bit set_req;
    bit set_bank;
    int j;
    if (RST_I) begin
      pos = -1; rd_k = -1;
      m_full[0] = 0; m_full[1] = 0;
      m_wb = 0; m_rb = 0; m_sym_ok = 0; m_ovf = 0; m_sym = 0;
      e_wr_en = 0; e_wr_bank = 0; e_wr_addr = 0;
      e_rd_en = 0; e_rd_bank = 0; e_rd_addr = 0; e_sop = 0; e_eop = 0;
    end else begin
      full_pre = m_full;
      set_req = 0; set_bank = 0;
      e_wr_en = 0; e_wr_bank = 0; e_wr_addr = 0;
      if (STB_I) begin
        if (SYNC_I) begin
          pos = 0;
        end else if (pos >= 0) begin
          pos = pos + 1;
          if (pos == SYML) pos = 0;
          if (pos >= LCP) begin
            j = pos - LCP;
            if (j == 0) begin
              m_sym_ok = !full_pre[m_wb];
              if (!m_sym_ok) m_ovf = 1;
            end
            if (m_sym_ok) begin
              e_wr_en = 1; e_wr_bank = m_wb; e_wr_addr = AW'(j);
              if (j == NFFT - 1) begin
                set_req = 1; set_bank = m_wb;
                m_wb = !m_wb;
                m_sym = m_sym + 16'd1;
              end
            end
          end
        end
      end
      e_rd_en = 0; e_rd_bank = 0; e_rd_addr = 0; e_sop = 0; e_eop = 0;
      if (rd_k < 0) begin
        if (full_pre[m_rb] && FFT_RDY_I) rd_k = 0;
      end else begin
        rd_k = rd_k + 1;
        if (rd_k <= NFFT) begin
          e_rd_en = 1; e_rd_bank = m_rb; e_rd_addr = AW'(rd_k - 1);
          e_sop = (rd_k == 1); e_eop = (rd_k == NFFT);
        end else begin
          m_full[m_rb] = 0;
          m_rb = !m_rb;
          rd_k = -1;
        end
      end
      if (set_req) m_full[set_bank] = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK_I) begin
    if (chk_en) begin
      check("wr", {WR_EN_O, WR_BANK_O, WR_ADDR_O}, {e_wr_en, e_wr_bank, e_wr_addr});
      check("rd", {RD_EN_O, RD_BANK_O, RD_ADDR_O, SOP_O, EOP_O},
            {e_rd_en, e_rd_bank, e_rd_addr, e_sop, e_eop});
      check("ovf", OVF_O, m_ovf);
      check("sym_cnt", SYM_CNT_O, m_sym);
      if (SOP_O === 1'b1 && exp_q.size() > 0) begin
        check("sop_bank", RD_BANK_O, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input bit s, input bit v);
    @(posedge CLK_I);
    #1;
    SYNC_I    = s;
    STB_I     = v;
    FFT_RDY_I = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_lvl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // gap_mode: 0 continuous, 1 every other cycle, 2 random gaps
  task automatic send_symbol(input bit sync_first, input int nsamp, input int gap_mode);
    for (int i = 0; i < nsamp; i++) begin
      if (gap_mode == 1 && i > 0) cyc(1'($urandom_range(0, 1)), 1'b0);
      if (gap_mode == 2) begin
        while ($urandom_range(0, 99) < 20) cyc(1'($urandom_range(0, 1)), 1'b0);
      end
      cyc(sync_first && (i == 0), 1'b1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit found;
    #1;
    RST_I = 1'b1;
    #2;
    chk_en = 1'b1;
    do_reset();

    // 1: single synced symbol, FFT ready
    rdy_lvl = 1; rdy_rand = 0;
    exp_q.push_back(1'b0);
    send_symbol(1'b1, SYML, 0);
    idle(90);
    check("t1_sym", SYM_CNT_O, 32'd1);
    check("t1_sop_left", exp_q.size(), 32'd0);

    // 2: three back-to-back symbols, FFT ready
    do_reset();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    send_symbol(1'b1, SYML, 0);
    send_symbol(1'b0, SYML, 0);
    send_symbol(1'b0, SYML, 0);
    idle(150);
    check("t2_sym", SYM_CNT_O, 32'd3);
    check("t2_ovf", OVF_O, 32'd0);
    check("t2_sop_left", exp_q.size(), 32'd0);

    // 3: FFT never ready while three symbols arrive, then ready
    do_reset();
    rdy_lvl = 0;
    send_symbol(1'b1, SYML, 0);
    send_symbol(1'b0, SYML, 0);
    send_symbol(1'b0, SYML, 0);
    idle(10);
    check("t3_sym", SYM_CNT_O, 32'd2);
    check("t3_ovf", OVF_O, 32'd1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    rdy_lvl = 1;
    idle(200);
    check("t3_sop_left", exp_q.size(), 32'd0);

    // 4: resync at body index 30, then a complete symbol
    do_reset();
    exp_q.push_back(1'b0);
    send_symbol(1'b1, LCP + 30, 0);
    send_symbol(1'b1, SYML, 0);
    idle(90);
    check("t4_sym", SYM_CNT_O, 32'd1);
    check("t4_sop_left", exp_q.size(), 32'd0);

    // 5: strobe on every other cycle
    do_reset();
    exp_q.push_back(1'b0);
    send_symbol(1'b1, SYML, 1);
    idle(90);
    check("t5_sym", SYM_CNT_O, 32'd1);
    check("t5_sop_left", exp_q.size(), 32'd0);

    // 6: reset in the middle of a read burst
    do_reset();
    send_symbol(1'b1, SYML, 0);
    cyc(1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK_I);
      if (RD_EN_O === 1'b1 && RD_ADDR_O === AW'(20)) begin
        found = 1;
        break;
      end
    end
    check("t6_burst_addr20", found, 32'd1);
    #2;
    RST_I = 1'b1;
    #1;
    check("t6_rst_ctl", {WR_EN_O, RD_EN_O, SOP_O, EOP_O, OVF_O, WR_BANK_O, RD_BANK_O}, 32'd0);
    check("t6_rst_addr", {WR_ADDR_O, RD_ADDR_O}, 32'd0);
    check("t6_rst_sym", SYM_CNT_O, 32'd0);
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    idle(150);

    // 7: randomized gaps, resyncs, truncated symbols and FFT readiness
    do_reset();
    rdy_rand = 1;
    for (int k = 0; k < 25; k++) begin
      send_symbol((k == 0) || ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SYML - 1)) : SYML,
                  2);
    end
    rdy_rand = 0; rdy_lvl = 1;
    idle(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
